ram_master: RTL and testbench

Bus-side sequencer that drives the single-port RAM strobe interface used by the MC14500B system: registered address, write strobe that commits on its falling edge, and a read path that is transparent while the strobe is low. It takes word-wide read/write requests over a valid/ready handshake, generates setup/strobe/hold timing, and returns read data or a write acknowledge as a one-cycle response pulse. It sits between the ICU/IO control logic and any RAM instance.

---
 rtl/ram_master.sv | 168 ++++++++++++++++
 tb/tb_ram_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: valid/ready request sequencer driving a strobe-write RAM with setup/strobe/hold timing.
// Defining RAM_MASTER_RMW_EN adds the req_op port and a read-modify-write datapath.
module ram_master #(
  parameter int WORD          = 1,
  parameter int SIZE_LOG      = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [SIZE_LOG-1:0] req_address,
  input  logic [WORD-1:0]     req_data,
`ifdef RAM_MASTER_RMW_EN
  input  logic [1:0]          req_op,
`endif
  output logic                rsp_valid,
  output logic [WORD-1:0]     rsp_data,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_out,
  input  logic [WORD-1:0]     ram_data_in,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD-1:0]     rsp_data_q, rsp_data_d;
  logic                ram_write_q, ram_write_d;
  logic                write_q, write_d;
  // Address/data registers survive reset so an interrupted strobe still commits coherently.
  logic [SIZE_LOG-1:0] addr_q = '0;
  logic [SIZE_LOG-1:0] addr_d;
  logic [WORD-1:0]     wdata_q = '0;
  logic [WORD-1:0]     wdata_d;

`ifdef RAM_MASTER_RMW_EN
  logic [1:0]          op_q, op_d;
  logic [WORD-1:0]     rmw_word;

  always_comb begin
    case (op_q)
      2'b01:   rmw_word = ram_data_in | wdata_q;
      2'b10:   rmw_word = ram_data_in & ~wdata_q;
      2'b11:   rmw_word = ram_data_in ^ wdata_q;
      default: rmw_word = wdata_q;
    endcase
  end
`endif

  // Handshake: a request is taken on the rising clk edge where req_valid && req_ready;
  // rsp_valid is a single-cycle pulse with no backpressure.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    ram_write_d = ram_write_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef RAM_MASTER_RMW_EN
    op_d        = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          addr_d  = req_address;
          wdata_d = req_data;
          write_d = req_write;
`ifdef RAM_MASTER_RMW_EN
          op_d    = req_write ? req_op : 2'b00;
`endif
          ready_d = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!write_q) begin
          rsp_data_d  = ram_data_in;
          rsp_valid_d = 1'b1;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end else begin
`ifdef RAM_MASTER_RMW_EN
          wdata_d    = rmw_word;
          rsp_data_d = (op_q != 2'b00) ? ram_data_in : wdata_q;
`else
          rsp_data_d = wdata_q;
`endif
          ram_write_d = 1'b1;
          cnt_d       = STROBE_LOAD;
          state_d     = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          ram_write_d = 1'b0;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ram_write_q <= 1'b0;
      write_q     <= 1'b0;
`ifdef RAM_MASTER_RMW_EN
      op_q        <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ram_write_q <= ram_write_d;
      write_q     <= write_d;
`ifdef RAM_MASTER_RMW_EN
      op_q        <= op_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign ram_write    = ram_write_q;
  assign ram_address  = addr_q;
  assign ram_data_out = wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: attached strobe RAM, transaction-level reference model, per-cycle compare.
module tb_ram_master;
  localparam int WORD = 8;
  localparam int SIZE_LOG = 8;
  localparam int S = 3;
`ifdef RAM_MASTER_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_write = 1'b0;
  logic [SIZE_LOG-1:0] req_address = '0;
  logic [WORD-1:0]     req_data = '0;
  logic [1:0]          req_op = 2'b00;
  logic                rsp_valid;
  logic [WORD-1:0]     rsp_data;
  logic                ram_write;
  logic [SIZE_LOG-1:0] ram_address;
  logic [WORD-1:0]     ram_data_out;
  logic [WORD-1:0]     ram_data_in;
  logic                busy;
  logic [1:0]          dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  ram_master #(.WORD(WORD), .SIZE_LOG(SIZE_LOG), .STROBE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
`ifdef RAM_MASTER_RMW_EN
    .req_op(req_op),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .busy(busy), .dbg_state(dbg_state)
  );

  // attached RAM: transparent read, commit on falling strobe
  logic [WORD-1:0] mem [0:255];
  logic ram_live = 1'b0;
  assign ram_data_in = mem[ram_address];
  always @(negedge ram_write) if (ram_live) mem[ram_address] = ram_data_out;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD-1:0] apply_op(input logic [1:0] op, input logic [WORD-1:0] old,
                                               input logic [WORD-1:0] d);
    case (op)
      2'b01:   return old | d;
      2'b10:   return old & ~d;
      2'b11:   return old ^ d;
      default: return d;
    endcase
  endfunction

  // reference model: one transaction at a time, timing expressed in edges after acceptance
  logic [WORD-1:0] ref_mem [0:255];
  logic [WORD-1:0] exp_q [$];
  int cyc, free_at, acc_edge, rsp_edge;
  bit acc_write;
  logic [SIZE_LOG-1:0] acc_addr;
  logic [WORD-1:0] acc_new;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; free_at = 2; acc_edge = -100; rsp_edge = -1; acc_write = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (req_valid && cyc >= free_at) begin
        logic [1:0] op_in;
        logic [WORD-1:0] old;
        op_in = RMW ? req_op : 2'b00;
        acc_edge = cyc;
        acc_write = req_write;
        acc_addr = req_address;
        old = ref_mem[req_address];
        if (!req_write) begin
          exp_q.push_back(old);
          rsp_edge = cyc + 1;
          free_at = cyc + 2;
        end else begin
          acc_new = apply_op(op_in, old, req_data);
          ref_mem[req_address] = acc_new;
          exp_q.push_back((op_in != 2'b00) ? old : acc_new);
          rsp_edge = cyc + 2 + S;
          free_at = cyc + 3 + S;
        end
      end
    end
  end

  // scoreboard / compare process
  int rsp_cnt = 0;
  int wr_hi = 0;
  logic [WORD-1:0] last_rsp = '0;
  logic [WORD-1:0] exp_v;
  bit in_txn, in_wr;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_ram_write", 32'(ram_write), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
    end else begin
      in_txn = (acc_edge >= 0) && (cyc >= acc_edge) && (cyc <= free_at - 2);
      in_wr  = acc_write && (acc_edge >= 0) && (cyc >= acc_edge + 1) && (cyc <= acc_edge + S);
      check("req_ready", 32'(req_ready), 32'(cyc + 1 >= free_at));
      check("busy", 32'(busy), 32'(in_txn));
      check("ram_write", 32'(ram_write), 32'(in_wr));
      check("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_edge));
      if (in_txn) check("ram_address", 32'(ram_address), 32'(acc_addr));
      if (in_wr) check("ram_data_out", 32'(ram_data_out), 32'(acc_new));
      if (cyc == rsp_edge) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          exp_v = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(exp_v));
        end
      end
      if (rsp_valid) begin rsp_cnt++; last_rsp = rsp_data; end
      if (ram_write) wr_hi++;
    end
  end

  // driver tasks
  task automatic do_req(input bit w, input logic [SIZE_LOG-1:0] a, input logic [WORD-1:0] d,
                        input logic [1:0] op, input bit keep, output int edge_o);
    req_write = w; req_address = a; req_data = d; req_op = RMW ? op : 2'b00;
    req_valid = 1'b1;
    edge_o = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (acc_edge == cyc && acc_edge > 0) begin edge_o = cyc; break; end
    end
    if (edge_o < 0) check("accept_timeout", 32'd1, 32'd0);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, e3, e4, r0, bad;
    for (int i = 0; i < 256; i++) begin
      logic [WORD-1:0] v;
      v = WORD'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    ram_live = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_edges(1);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // directed write 0xA5 -> 0x10
    wr_hi = 0; r0 = rsp_cnt;
    do_req(1'b1, 8'h10, 8'hA5, 2'b00, 1'b0, e1);
    wait_edges(S + 3);
    check("wr_strobe_len", 32'(wr_hi), 32'd3);
    check("wr_commit", 32'(mem[8'h10]), 32'h0A5);
    check("wr_rsp_data", 32'(last_rsp), 32'h0A5);
    check("wr_rsp_count", 32'(rsp_cnt - r0), 32'd1);

    // directed read back
    wr_hi = 0;
    do_req(1'b0, 8'h10, 8'h00, 2'b00, 1'b0, e2);
    wait_edges(2);
    check("rd_rsp_data", 32'(last_rsp), 32'h0A5);
    check("rd_no_strobe", 32'(wr_hi), 32'd0);

    // valid held high, alternating write/read
    do_req(1'b1, 8'h11, 8'h5A, 2'b00, 1'b1, e1);
    do_req(1'b0, 8'h11, 8'h00, 2'b00, 1'b1, e2);
    do_req(1'b1, 8'h12, 8'h33, 2'b00, 1'b1, e3);
    do_req(1'b0, 8'h12, 8'h00, 2'b00, 1'b0, e4);
    check("spacing_wr_rd", 32'(e2 - e1), 32'd6);
    check("spacing_rd_wr", 32'(e3 - e2), 32'd2);
    wait_edges(2);
    check("stream_rd_data", 32'(last_rsp), 32'h033);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      bit w, keep;
      w = 1'($urandom_range(0, 1));
      keep = 1'($urandom_range(0, 1));
      do_req(w, 8'($urandom_range(0, 15)), WORD'($urandom), 2'($urandom_range(0, 3)), keep, e1);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    req_valid = 1'b0;
    wait_edges(S + 4);

    // reset in the second strobe cycle of write 0x3C -> 0x20
    r0 = rsp_cnt;
    do_req(1'b1, 8'h20, 8'h3C, 2'b00, 1'b0, e1);
    repeat (2) @(posedge clk);
    #2;
    check("strobe_before_reset", 32'(ram_write), 32'd1);
    reset = 1'b1;
    #1;
    check("strobe_dropped", 32'(ram_write), 32'd0);
    check("reset_commit", 32'(mem[8'h20]), 32'h03C);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_edges(1);
    check("ready_after_reset2", 32'(req_ready), 32'd1);
    wait_edges(6);
    check("no_rsp_after_reset", 32'(rsp_cnt - r0), 32'd0);

`ifdef RAM_MASTER_RMW_EN
    do_req(1'b1, 8'h01, 8'hF0, 2'b00, 1'b0, e1);
    wait_edges(S + 3);
    do_req(1'b1, 8'h01, 8'hFF, 2'b11, 1'b0, e1);
    wait_edges(S + 3);
    check("rmw_xor_rsp", 32'(last_rsp), 32'h0F0);
    check("rmw_xor_mem", 32'(mem[8'h01]), 32'h00F);
    do_req(1'b1, 8'h01, 8'h0F, 2'b10, 1'b0, e1);
    wait_edges(S + 3);
    check("rmw_clr_mem", 32'(mem[8'h01]), 32'h000);
`endif

    wait_edges(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_sweep", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
